rf_write_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources:
//  ALU (Alu*) and memory load unit (Mem*). Uses round-robin arbitration with

---
 rtl/rf_write_arbiter.sv | 106 ++++++++++
 tb/tb_rf_write_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU and the load unit,
// with a registered write stage. Define RF_WRITE_ARB_BYPASS_EN to forward the in-flight write to A/B.
module rf_write_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int RESET_PTR    = 0,
    parameter int ZERO_PROTECT = 0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Hold,
    input  logic                  AluValid,
    input  logic [ADDR_WIDTH-1:0] AluAddr,
    input  logic [DATA_WIDTH-1:0] AluData,
    output logic                  AluReady,
    input  logic                  MemValid,
    input  logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic [DATA_WIDTH-1:0] MemData,
    output logic                  MemReady,
    output logic                  WriteEnable,
    output logic [ADDR_WIDTH-1:0] SelectInput,
    output logic [DATA_WIDTH-1:0] In,
    input  logic [ADDR_WIDTH-1:0] SelectA,
    input  logic [ADDR_WIDTH-1:0] SelectB,
    input  logic [DATA_WIDTH-1:0] RfA,
    input  logic [DATA_WIDTH-1:0] RfB,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B
);

    // prio_q: 0 = ALU wins a tie, 1 = Mem wins a tie
    logic                  prio_q, prio_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  alu_gnt, mem_gnt, drop;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_data;

    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (Reset && !Hold) begin
            if (AluValid && MemValid) begin
                alu_gnt = !prio_q;
                mem_gnt = prio_q;
            end else begin
                alu_gnt = AluValid;
                mem_gnt = MemValid;
            end
        end

        gnt_addr = mem_gnt ? MemAddr : AluAddr;
        gnt_data = mem_gnt ? MemData : AluData;
        // Register 0 writes are still handshaken so the requester is not stalled forever.
        drop     = (ZERO_PROTECT != 0) && (gnt_addr == '0);

        prio_d = prio_q;
        if (alu_gnt) begin
            prio_d = 1'b1;
        end else if (mem_gnt) begin
            prio_d = 1'b0;
        end

        we_d   = (alu_gnt || mem_gnt) && !drop;
        sel_d  = we_d ? gnt_addr : sel_q;
        data_d = we_d ? gnt_data : data_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prio_q <= (RESET_PTR != 0);
            we_q   <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            prio_q <= prio_d;
            we_q   <= we_d;
            sel_q  <= sel_d;
            data_q <= data_d;
        end
    end

    assign AluReady    = alu_gnt;
    assign MemReady    = mem_gnt;
    assign WriteEnable = we_q;
    assign SelectInput = sel_q;
    assign In          = data_q;

`ifdef RF_WRITE_ARB_BYPASS_EN
    logic fwd_a, fwd_b;

    assign fwd_a = we_q && (sel_q == SelectA) && !((ZERO_PROTECT != 0) && (SelectA == '0));
    assign fwd_b = we_q && (sel_q == SelectB) && !((ZERO_PROTECT != 0) && (SelectB == '0));
    assign A     = fwd_a ? data_q : RfA;
    assign B     = fwd_b ? data_q : RfB;
`else
    // Selects only feed the register file directly in this build.
    logic unused_sel;

    assign unused_sel = ^{SelectA, SelectB};
    assign A          = RfA;
    assign B          = RfB;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, corner sequences and random traffic
// against a behavioural model, on a default instance and a RESET_PTR=1/ZERO_PROTECT=1 instance.
module tb_rf_write_arbiter;

    logic        Clock, Reset, Hold;
    logic        AluValid, MemValid;
    logic [3:0]  AluAddr, MemAddr, SelectA, SelectB;
    logic [15:0] AluData, MemData;
    logic        rf_clr;

    logic        ar0, mr0, we0, ar1, mr1, we1;
    logic [3:0]  sel0, sel1;
    logic [15:0] in0, in1, a0, b0, a1, b1, rfa0, rfb0, rfa1, rfb1;

    logic [15:0] rf0 [16];
    logic [15:0] rf1 [16];

    int checks = 0;
    int errors = 0;

    rf_write_arbiter dut (
        .Clock(Clock), .Reset(Reset), .Hold(Hold),
        .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(ar0),
        .MemValid(MemValid), .MemAddr(MemAddr), .MemData(MemData), .MemReady(mr0),
        .WriteEnable(we0), .SelectInput(sel0), .In(in0),
        .SelectA(SelectA), .SelectB(SelectB), .RfA(rfa0), .RfB(rfb0), .A(a0), .B(b0)
    );

    rf_write_arbiter #(.RESET_PTR(1), .ZERO_PROTECT(1)) dut_zp (
        .Clock(Clock), .Reset(Reset), .Hold(Hold),
        .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(ar1),
        .MemValid(MemValid), .MemAddr(MemAddr), .MemData(MemData), .MemReady(mr1),
        .WriteEnable(we1), .SelectInput(sel1), .In(in1),
        .SelectA(SelectA), .SelectB(SelectB), .RfA(rfa1), .RfB(rfb1), .A(a1), .B(b1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Register files seen by each instance
    always @(posedge Clock) begin
        if (rf_clr) begin
            for (int r = 0; r < 16; r++) begin
                rf0[r] <= 16'h0;
                rf1[r] <= 16'h0;
            end
        end else begin
            if (we0) rf0[sel0] <= in0;
            if (we1) rf1[sel1] <= in1;
        end
    end

    assign rfa0 = rf0[SelectA];
    assign rfb0 = rf0[SelectB];
    assign rfa1 = rf1[SelectA];
    assign rfb1 = rf1[SelectB];

    // Behavioural model: m_last = last granted source (0 ALU, 1 Mem), pending write, reg contents
    logic        m_last [2];
    logic        m_we   [2];
    logic [3:0]  m_sel  [2];
    logic [15:0] m_in   [2];
    logic [15:0] mrf    [2][16];

    // 0 = none, 1 = ALU, 2 = Mem
    function automatic int mgrant(int i);
        if (!Reset || Hold) return 0;
        if (AluValid && MemValid) return m_last[i] ? 1 : 2;
        if (AluValid) return 1;
        if (MemValid) return 2;
        return 0;
    endfunction

    function automatic logic [15:0] mread(int i, logic [3:0] s);
`ifdef RF_WRITE_ARB_BYPASS_EN
        if (m_we[i] && m_sel[i] == s && !(i == 1 && s == 4'd0)) return m_in[i];
`endif
        return mrf[i][s];
    endfunction

    always @(posedge Clock or negedge Reset) begin
        int          g;
        logic [3:0]  ad;
        logic [15:0] dt;
        if (rf_clr) begin
            for (int i = 0; i < 2; i++)
                for (int r = 0; r < 16; r++) mrf[i][r] = 16'h0;
        end
        if (!Reset) begin
            m_last[0] = 1'b1;
            m_last[1] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_we[i]  = 1'b0;
                m_sel[i] = 4'h0;
                m_in[i]  = 16'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                g = mgrant(i);
                if (m_we[i]) mrf[i][m_sel[i]] = m_in[i];
                m_we[i] = 1'b0;
                if (g != 0) begin
                    m_last[i] = (g == 2);
                    ad = (g == 2) ? MemAddr : AluAddr;
                    dt = (g == 2) ? MemData : AluData;
                    if (!(i == 1 && ad == 4'd0)) begin
                        m_we[i]  = 1'b1;
                        m_sel[i] = ad;
                        m_in[i]  = dt;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model();
        int g0, g1;
        g0 = mgrant(0);
        g1 = mgrant(1);
        chk("rnd_alu_ready0", ar0, g0 == 1);
        chk("rnd_mem_ready0", mr0, g0 == 2);
        chk("rnd_we0", we0, m_we[0]);
        chk("rnd_sel0", sel0, m_sel[0]);
        chk("rnd_in0", in0, m_in[0]);
        chk("rnd_a0", a0, mread(0, SelectA));
        chk("rnd_b0", b0, mread(0, SelectB));
        chk("rnd_alu_ready1", ar1, g1 == 1);
        chk("rnd_mem_ready1", mr1, g1 == 2);
        chk("rnd_we1", we1, m_we[1]);
        chk("rnd_sel1", sel1, m_sel[1]);
        chk("rnd_in1", in1, m_in[1]);
        chk("rnd_a1", a1, mread(1, SelectA));
        chk("rnd_b1", b1, mread(1, SelectB));
    endtask

    typedef struct {
        logic        hold, av;
        logic [3:0]  aa;
        logic [15:0] ad;
        logic        mv;
        logic [3:0]  ma;
        logic [15:0] md;
        logic [3:0]  sa, sb;
        logic        ar, mr, we;
        logic [3:0]  sel;
        logic [15:0] din, ea, eb;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // hold av aa ad mv ma md sa sb | ar mr we sel in A B
        tbl[0] = '{1'b0, 1'b1, 4'd3, 16'h1111, 1'b1, 4'd3, 16'h2222, 4'd0, 4'd0,
                   1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 16'h0};
        tbl[1] = '{1'b0, 1'b1, 4'd5, 16'd37, 1'b1, 4'd3, 16'h2222, 4'd0, 4'd0,
                   1'b0, 1'b1, 1'b1, 4'd3, 16'h1111, 16'h0, 16'h0};
        tbl[2] = '{1'b0, 1'b1, 4'd5, 16'd37, 1'b1, 4'd7, 16'h0BEE, 4'd0, 4'd0,
                   1'b1, 1'b0, 1'b1, 4'd3, 16'h2222, 16'h0, 16'h0};
        tbl[3] = '{1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'h0BEE, 4'd3, 4'd0,
                   1'b0, 1'b1, 1'b1, 4'd5, 16'd37, 16'h2222, 16'h0};
        tbl[4] = '{1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 16'h1234, 4'd5, 4'd3,
                   1'b0, 1'b0, 1'b1, 4'd7, 16'h0BEE, 16'd37, 16'h2222};
        tbl[5] = '{1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 16'h1234, 4'd7, 4'd5,
                   1'b0, 1'b0, 1'b0, 4'd7, 16'h0BEE, 16'h0BEE, 16'd37};
        tbl[6] = '{1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 16'h1234, 4'd0, 4'd0,
                   1'b0, 1'b0, 1'b0, 4'd7, 16'h0BEE, 16'h0, 16'h0};
        tbl[7] = '{1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 16'h1234, 4'd0, 4'd0,
                   1'b0, 1'b1, 1'b0, 4'd7, 16'h0BEE, 16'h0, 16'h0};
        tbl[8] = '{1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0,
                   1'b0, 1'b0, 1'b1, 4'd9, 16'h1234, 16'h0, 16'h0};
        tbl[9] = '{1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd9, 4'd7,
                   1'b0, 1'b0, 1'b0, 4'd9, 16'h1234, 16'h1234, 16'h0BEE};

        Reset = 1'b0; rf_clr = 1'b1; Hold = 1'b0;
        AluValid = 1'b1; AluAddr = 4'd1; AluData = 16'h1;
        MemValid = 1'b1; MemAddr = 4'd2; MemData = 16'h2;
        SelectA = 4'd0; SelectB = 4'd0;
        #1;
        chk("rst_we", we0, 1'b0);
        chk("rst_sel", sel0, 4'd0);
        chk("rst_in", in0, 16'h0);
        chk("rst_alu_ready", ar0, 1'b0);
        chk("rst_mem_ready", mr0, 1'b0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        rf_clr = 1'b0; AluValid = 1'b0; MemValid = 1'b0;
        Reset = 1'b1;

        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            Hold = tbl[k].hold;
            AluValid = tbl[k].av; AluAddr = tbl[k].aa; AluData = tbl[k].ad;
            MemValid = tbl[k].mv; MemAddr = tbl[k].ma; MemData = tbl[k].md;
            SelectA = tbl[k].sa; SelectB = tbl[k].sb;
            #1;
            chk($sformatf("vec%0d_alu_ready", k), ar0, tbl[k].ar);
            chk($sformatf("vec%0d_mem_ready", k), mr0, tbl[k].mr);
            chk($sformatf("vec%0d_we", k), we0, tbl[k].we);
            chk($sformatf("vec%0d_sel", k), sel0, tbl[k].sel);
            chk($sformatf("vec%0d_in", k), in0, tbl[k].din);
            chk($sformatf("vec%0d_a", k), a0, tbl[k].ea);
            chk($sformatf("vec%0d_b", k), b0, tbl[k].eb);
        end

        // Reset asserted while a write is in flight
        @(negedge Clock);
        Hold = 1'b0; SelectA = 4'd0; SelectB = 4'd0;
        AluValid = 1'b1; AluAddr = 4'd2; AluData = 16'h0055; MemValid = 1'b0;
        @(posedge Clock);
        #2;
        chk("mid_we_before", we0, 1'b1);
        MemValid = 1'b1;
        Reset = 1'b0;
        #1;
        chk("mid_rst_we", we0, 1'b0);
        chk("mid_rst_sel", sel0, 4'd0);
        chk("mid_rst_in", in0, 16'h0);
        chk("mid_rst_alu_ready", ar0, 1'b0);
        chk("mid_rst_mem_ready", mr0, 1'b0);
        @(negedge Clock);
        Reset = 1'b1; AluValid = 1'b0; MemValid = 1'b0;

        // Register 0 write on the protected instance
        @(negedge Clock);
        AluValid = 1'b1; AluAddr = 4'd0; AluData = 16'd99;
        #1;
        chk("zp_alu_ready", ar1, 1'b1);
        @(negedge Clock);
        AluValid = 1'b0;
        #1;
        chk("zp_we", we1, 1'b0);
        chk("zp_in_held", in1, 16'h0);
        chk("zp_main_we", we0, 1'b1);
        chk("zp_main_in", in0, 16'd99);
        @(negedge Clock);
        #1;
        chk("zp_r0_kept", a1, 16'h0);

        // Read during the write cycle: forwarded only with bypass
        @(negedge Clock);
        AluValid = 1'b1; AluAddr = 4'd12; AluData = 16'd7;
        @(negedge Clock);
        AluData = 16'd42;
        @(negedge Clock);
        AluValid = 1'b0; SelectA = 4'd12; SelectB = 4'd12;
        #1;
`ifdef RF_WRITE_ARB_BYPASS_EN
        chk("byp_a_write_cycle", a0, 16'd42);
        chk("byp_b_write_cycle", b0, 16'd42);
`else
        chk("byp_a_write_cycle", a0, 16'd7);
        chk("byp_b_write_cycle", b0, 16'd7);
`endif
        @(negedge Clock);
        #1;
        chk("byp_a_after", a0, 16'd42);
        chk("byp_b_after", b0, 16'd42);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            @(negedge Clock);
            Hold = ($urandom_range(0, 7) == 0);
            if (!(AluValid && $urandom_range(0, 3) != 0)) begin
                AluAddr = 4'($urandom_range(0, 15));
                AluData = 16'($urandom_range(0, 65535));
            end
            if (!(MemValid && $urandom_range(0, 3) != 0)) begin
                MemAddr = 4'($urandom_range(0, 15));
                MemData = 16'($urandom_range(0, 65535));
            end
            AluValid = ($urandom_range(0, 2) != 0);
            MemValid = ($urandom_range(0, 2) != 0);
            SelectA = ($urandom_range(0, 1) == 0) ? m_sel[0] : 4'($urandom_range(0, 15));
            SelectB = ($urandom_range(0, 1) == 0) ? m_sel[1] : 4'($urandom_range(0, 15));
            #1;
            chk_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
